// File: rtl/uart_mmio_bridge_pkg.sv
// Shared definitions for the buffered UART MMIO bridge: register map,
// control bits, TX drain states and the status word layout.
package uart_mmio_bridge_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_RXSTAT = 2'd1;
    localparam logic [1:0] REG_TXSTAT = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int CTRL_FLUSH_RX = 0;
    localparam int CTRL_FLUSH_TX = 1;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_LAUNCH = 2'd1,
        TX_WAITLO = 2'd2,
        TX_WAITHI = 2'd3
    } tx_state_t;

    // Status word: count in the high byte, sticky overflow at bit 2.
    function automatic logic [15:0] pack_status(
        input logic [7:0] count,
        input logic       ovf,
        input logic       bit1,
        input logic       bit0
    );
        return {count, 5'b0, ovf, bit1, bit0};
    endfunction

endpackage

// File: rtl/uart_mmio_bridge_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; a pop frees space for a push in
// the same cycle and flush zeroes both pointers, discarding any push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     I_clk,
    input  logic                     I_reset,
    input  logic                     I_push,
    input  logic                     I_pop,
    input  logic                     I_flush,
    input  logic [WIDTH-1:0]         I_data,
    output logic [WIDTH-1:0]         O_head,
    output logic [$clog2(DEPTH):0]   O_count,
    output logic                     O_full,
    output logic                     O_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign O_empty   = (r_wr_ptr == r_rd_ptr);
    assign O_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign O_count   = r_wr_ptr - r_rd_ptr;
    assign O_head    = r_mem[r_rd_ptr[AW-1:0]];

    assign w_do_pop  = I_pop & ~O_empty;
    assign w_do_push = I_push & (~O_full | w_do_pop);

    always_ff @(posedge I_clk) begin
        if (I_reset || I_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge I_clk) begin
        if (w_do_push && !I_flush) r_mem[r_wr_ptr[AW-1:0]] <= I_data;
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART peripheral: RX/TX FIFOs, sticky overflow flags, a fixed
// one-cycle bus response and a drain FSM that feeds uart_tx from the TX FIFO.
module uart_mmio_bridge
    import uart_mmio_bridge_pkg::*;
#(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 8
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_exec,
    input  logic        I_write,
    input  logic [1:0]  I_addr,
    input  logic [7:0]  I_data,
    output logic [15:0] O_data,
    output logic        O_data_ready,
    output logic        O_busy,
    input  logic        I_rx_data_ready,
    input  logic [7:0]  I_rx_data,
    output logic        O_tx_exec,
    output logic [7:0]  O_tx_data,
    input  logic        I_tx_ready
);

    localparam int RXCW = $clog2(RX_DEPTH) + 1;
    localparam int TXCW = $clog2(TX_DEPTH) + 1;

    logic [15:0] r_data;
    logic        r_data_ready;
    logic        r_busy;
    logic        r_tx_exec;
    logic [7:0]  r_tx_data;
    logic        r_rx_ovf;
    logic        r_tx_ovf;
    tx_state_t   r_state;
    tx_state_t   w_state_next;

    logic            w_accept, w_rd, w_wr;
    logic            w_rx_pop, w_rx_flush, w_rx_drop;
    logic            w_tx_push, w_tx_pop, w_tx_flush, w_tx_drop;
    logic            w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic            w_tx_idle;
    logic [7:0]      w_rx_head, w_tx_head;
    logic [RXCW-1:0] w_rx_count;
    logic [TXCW-1:0] w_tx_count;
    logic [7:0]      w_rx_count8, w_tx_count8;
    logic [15:0]     w_rdata;

    assign w_accept   = I_exec & ~r_busy;
    assign w_rd       = w_accept & ~I_write;
    assign w_wr       = w_accept & I_write;

    assign w_rx_pop   = w_rd & (I_addr == REG_DATA) & ~w_rx_empty;
    assign w_tx_push  = w_wr & (I_addr == REG_DATA);
    assign w_rx_flush = w_wr & (I_addr == REG_CTRL) & I_data[CTRL_FLUSH_RX];
    assign w_tx_flush = w_wr & (I_addr == REG_CTRL) & I_data[CTRL_FLUSH_TX];

    // A simultaneous pop makes room, and a flush discards the push silently.
    assign w_rx_drop  = I_rx_data_ready & w_rx_full & ~w_rx_pop & ~w_rx_flush;
    assign w_tx_drop  = w_tx_push & w_tx_full & ~w_tx_pop & ~w_tx_flush;

    assign w_tx_idle   = w_tx_empty & (r_state == TX_IDLE) & I_tx_ready;
    assign w_rx_count8 = 8'(w_rx_count);
    assign w_tx_count8 = 8'(w_tx_count);

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .I_clk   (I_clk),
        .I_reset (I_reset),
        .I_push  (I_rx_data_ready),
        .I_pop   (w_rx_pop),
        .I_flush (w_rx_flush),
        .I_data  (I_rx_data),
        .O_head  (w_rx_head),
        .O_count (w_rx_count),
        .O_full  (w_rx_full),
        .O_empty (w_rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .I_clk   (I_clk),
        .I_reset (I_reset),
        .I_push  (w_tx_push),
        .I_pop   (w_tx_pop),
        .I_flush (w_tx_flush),
        .I_data  (I_data),
        .O_head  (w_tx_head),
        .O_count (w_tx_count),
        .O_full  (w_tx_full),
        .O_empty (w_tx_empty)
    );

    always_comb begin
        w_rdata = 16'h0000;
        if (w_rd) begin
            case (I_addr)
                REG_DATA:   w_rdata = w_rx_empty ? 16'h0000 : {8'h00, w_rx_head};
                REG_RXSTAT: w_rdata = pack_status(w_rx_count8, r_rx_ovf, 1'b0, ~w_rx_empty);
                REG_TXSTAT: w_rdata = pack_status(w_tx_count8, r_tx_ovf, w_tx_idle, ~w_tx_full);
                default:    w_rdata = 16'h0000;
            endcase
        end
    end

    // Bus response and sticky flags; a new overflow beats clear-on-read.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_data       <= 16'h0000;
            r_data_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_rx_ovf     <= 1'b0;
            r_tx_ovf     <= 1'b0;
        end else begin
            r_busy       <= w_accept;
            r_data_ready <= w_accept;
            if (w_accept) r_data <= w_rdata;
            r_rx_ovf <= (r_rx_ovf & ~(w_rd & (I_addr == REG_RXSTAT))) | w_rx_drop;
            r_tx_ovf <= (r_tx_ovf & ~(w_rd & (I_addr == REG_TXSTAT))) | w_tx_drop;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_state   <= TX_IDLE;
            r_tx_exec <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_tx_exec <= w_tx_pop;
            if (w_tx_pop) r_tx_data <= w_tx_head;
        end
    end

    // Exec is the registered pop, so it is high only in the LAUNCH cycle.
    always_comb begin
        w_state_next = r_state;
        w_tx_pop     = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (!w_tx_empty && I_tx_ready) begin
                    w_tx_pop     = 1'b1;
                    w_state_next = TX_LAUNCH;
                end
            end
            TX_LAUNCH: w_state_next = TX_WAITLO;
            TX_WAITLO: if (!I_tx_ready) w_state_next = TX_WAITHI;
            TX_WAITHI: if (I_tx_ready) w_state_next = TX_IDLE;
            default:   w_state_next = TX_IDLE;
        endcase
    end

    assign O_data       = r_data;
    assign O_data_ready = r_data_ready;
    assign O_busy       = r_busy;
    assign O_tx_exec    = r_tx_exec;
    assign O_tx_data    = r_tx_data;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Scoreboard bench for uart_mmio_bridge: bus reads push expectations, a monitor
// checks each response; a uart_tx model checks every launched byte.
module tb_uart_mmio_bridge;

    logic        clk = 1'b0;
    logic        I_reset = 1'b1;
    logic        I_exec = 1'b0;
    logic        I_write = 1'b0;
    logic [1:0]  I_addr = 2'd0;
    logic [7:0]  I_data = 8'h00;
    logic [15:0] O_data;
    logic        O_data_ready;
    logic        O_busy;
    logic        I_rx_data_ready = 1'b0;
    logic [7:0]  I_rx_data = 8'h00;
    logic        O_tx_exec;
    logic [7:0]  O_tx_data;
    logic        txReady = 1'b1;

    typedef struct {
        logic        isRead;
        logic [15:0] data;
        int          due;
        string       name;
    } busExp_t;

    busExp_t    busQ[$];
    logic [7:0] txQ[$];
    busExp_t    monE;
    logic [7:0] txExp;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         txSent = 0;
    int         txCnt = 0;
    int         sentBefore;
    logic       txHold = 1'b0;
    logic       prevExec = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_mmio_bridge #(.RX_DEPTH(16), .TX_DEPTH(8)) dut (
        .I_clk           (clk),
        .I_reset         (I_reset),
        .I_exec          (I_exec),
        .I_write         (I_write),
        .I_addr          (I_addr),
        .I_data          (I_data),
        .O_data          (O_data),
        .O_data_ready    (O_data_ready),
        .O_busy          (O_busy),
        .I_rx_data_ready (I_rx_data_ready),
        .I_rx_data       (I_rx_data),
        .O_tx_exec       (O_tx_exec),
        .O_tx_data       (O_tx_data),
        .I_tx_ready      (txReady)
    );

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [1:0] addr, input logic [7:0] data,
                                 input logic [15:0] exp, input string name);
        busExp_t e;
        @(negedge clk);
        e.isRead = !wr;
        e.data   = exp;
        e.due    = cyc + 1;
        e.name   = name;
        busQ.push_back(e);
        I_exec  = 1'b1;
        I_write = wr;
        I_addr  = addr;
        I_data  = data;
        @(negedge clk);
        I_exec  = 1'b0;
    endtask

    task automatic rxByte(input logic [7:0] b);
        @(negedge clk);
        I_rx_data_ready = 1'b1;
        I_rx_data       = b;
        @(negedge clk);
        I_rx_data_ready = 1'b0;
    endtask

    task automatic waitTxDrain(input string name);
        int n = 0;
        while ((txQ.size() != 0 || !txReady || txCnt != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n >= 500) begin
            errors++;
            $display("[TB] FAIL %s actual=timeout expected=drained pending=%0d", name, txQ.size());
        end
    endtask

    // Bus response monitor: every O_data_ready must match the oldest request.
    always @(negedge clk) begin
        if (O_data_ready) begin
            if (busQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_response actual=%h expected=none", O_data);
            end else begin
                monE = busQ.pop_front();
                checkOutput({monE.name, "_latency"}, 16'(cyc), 16'(monE.due));
                checkOutput({monE.name, "_busy"}, 16'(O_busy), 16'd1);
                if (monE.isRead) checkOutput(monE.name, O_data, monE.data);
            end
        end
    end

    // uart_tx model plus launch checker: ready drops for 10 cycles after exec.
    always @(negedge clk) begin
        if (O_tx_exec) begin
            if (prevExec) begin
                checks++;
                errors++;
                $display("[TB] FAIL tx_exec_width actual=2+ expected=1");
            end else begin
                checkOutput("tx_exec_while_busy", 16'(txReady), 16'd1);
                if (txQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_tx actual=%h expected=none", O_tx_data);
                end else begin
                    txExp = txQ.pop_front();
                    checkOutput("tx_data", 16'(O_tx_data), 16'(txExp));
                end
                txSent++;
            end
        end
        prevExec = O_tx_exec;
        if (txHold) begin
            txReady = 1'b0;
            txCnt   = 0;
        end else if (O_tx_exec) begin
            txReady = 1'b0;
            txCnt   = 10;
        end else if (txCnt > 0) begin
            txCnt--;
            if (txCnt == 0) txReady = 1'b1;
        end else begin
            txReady = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        busExp_t e;
        int n;

        repeat (3) @(negedge clk);
        checkOutput("rst_data", O_data, 16'h0000);
        checkOutput("rst_ready", 16'(O_data_ready), 16'd0);
        checkOutput("rst_busy", 16'(O_busy), 16'd0);
        checkOutput("rst_tx_exec", 16'(O_tx_exec), 16'd0);
        checkOutput("rst_tx_data", 16'(O_tx_data), 16'd0);
        I_reset = 1'b0;

        $display("[TB] reset state reads");
        applyStimulus(1'b0, 2'd1, 8'h00, 16'h0000, "t1_rxstat");
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0000, "t1_data_empty");
        applyStimulus(1'b0, 2'd3, 8'h00, 16'h0000, "t1_ctrl_read");

        $display("[TB] three rx bytes");
        rxByte(8'h41); rxByte(8'h42); rxByte(8'h43);
        applyStimulus(1'b0, 2'd1, 8'h00, 16'h0301, "t2_rxstat");
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0041, "t2_data0");
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0042, "t2_data1");
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0043, "t2_data2");
        applyStimulus(1'b0, 2'd1, 8'h00, 16'h0000, "t2_rxstat_empty");

        $display("[TB] rx overflow");
        for (int i = 0; i < 17; i++) rxByte(8'h60 + 8'(i));
        applyStimulus(1'b0, 2'd1, 8'h00, 16'h1005, "t3_rxstat_ovf");
        applyStimulus(1'b0, 2'd1, 8'h00, 16'h1001, "t3_rxstat_cleared");
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b0, 2'd0, 8'h00, 16'h0060 + 16'(i), $sformatf("t3_data%0d", i));
        applyStimulus(1'b0, 2'd1, 8'h00, 16'h0000, "t3_rxstat_empty");

        $display("[TB] tx drain");
        sentBefore = txSent;
        txQ.push_back(8'h55);
        txQ.push_back(8'hAA);
        applyStimulus(1'b1, 2'd0, 8'h55, 16'h0000, "t4_wr55");
        applyStimulus(1'b1, 2'd0, 8'hAA, 16'h0000, "t4_wrAA");
        waitTxDrain("t4_drain");
        checkOutput("t4_tx_count", 16'(txSent - sentBefore), 16'd2);
        applyStimulus(1'b0, 2'd2, 8'h00, 16'h0003, "t4_txstat");

        $display("[TB] tx overflow");
        txHold = 1'b1;
        repeat (2) @(negedge clk);
        sentBefore = txSent;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) txQ.push_back(8'h80 + 8'(i));
            applyStimulus(1'b1, 2'd0, 8'h80 + 8'(i), 16'h0000, $sformatf("t5_wr%0d", i));
        end
        applyStimulus(1'b0, 2'd2, 8'h00, 16'h0804, "t5_txstat_ovf");
        applyStimulus(1'b0, 2'd2, 8'h00, 16'h0800, "t5_txstat_cleared");
        txHold = 1'b0;
        waitTxDrain("t5_drain");
        checkOutput("t5_tx_count", 16'(txSent - sentBefore), 16'd8);
        applyStimulus(1'b0, 2'd2, 8'h00, 16'h0003, "t5_txstat_idle");

        $display("[TB] simultaneous pop and push on full rx");
        for (int i = 0; i < 16; i++) rxByte(8'h20 + 8'(i));
        @(negedge clk);
        e.isRead = 1'b1;
        e.data   = 16'h0020;
        e.due    = cyc + 1;
        e.name   = "t6_pop_push";
        busQ.push_back(e);
        I_exec = 1'b1; I_write = 1'b0; I_addr = 2'd0;
        I_rx_data_ready = 1'b1; I_rx_data = 8'h30;
        @(negedge clk);
        I_exec = 1'b0;
        I_rx_data_ready = 1'b0;
        applyStimulus(1'b0, 2'd1, 8'h00, 16'h1001, "t6_rxstat_full");

        txHold = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 2'd0, 8'h11, 16'h0000, "t6_wr11");
        applyStimulus(1'b1, 2'd0, 8'h22, 16'h0000, "t6_wr22");
        applyStimulus(1'b0, 2'd2, 8'h00, 16'h0201, "t6_txstat_two");
        applyStimulus(1'b1, 2'd3, 8'h03, 16'h0000, "t6_flush");
        applyStimulus(1'b0, 2'd1, 8'h00, 16'h0000, "t6_rxstat_flushed");
        applyStimulus(1'b0, 2'd2, 8'h00, 16'h0001, "t6_txstat_flushed");
        txHold = 1'b0;
        repeat (20) @(negedge clk);
        applyStimulus(1'b0, 2'd2, 8'h00, 16'h0003, "t6_txstat_idle");

        $display("[TB] reset during launch");
        txQ.push_back(8'h77);
        applyStimulus(1'b1, 2'd0, 8'h77, 16'h0000, "t6_wr77");
        n = 0;
        while (!O_tx_exec && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("[TB] FAIL t6_launch_wait actual=timeout expected=exec");
        end
        I_reset = 1'b1;
        I_exec  = 1'b1; I_write = 1'b0; I_addr = 2'd1;
        @(negedge clk);
        checkOutput("t6_rst_tx_exec", 16'(O_tx_exec), 16'd0);
        checkOutput("t6_rst_ready", 16'(O_data_ready), 16'd0);
        checkOutput("t6_rst_busy", 16'(O_busy), 16'd0);
        I_reset = 1'b0;
        I_exec  = 1'b0;
        waitTxDrain("t6_post_reset_drain");
        applyStimulus(1'b0, 2'd2, 8'h00, 16'h0003, "t6_txstat_after_reset");
        applyStimulus(1'b0, 2'd1, 8'h00, 16'h0000, "t6_rxstat_after_reset");

        repeat (3) @(negedge clk);
        checkOutput("pending_responses", 16'(busQ.size()), 16'd0);
        checkOutput("pending_tx", 16'(txQ.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
